// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sharing one ALU, one operation in flight
// Grants alternate on response completion; results are held until the owner takes them.
module alu_arbiter #(
    parameter int PRIO_RESET = 0,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_rs,
    input  logic [31:0]      req0_rt,
    input  logic [3:0]       req0_ctrl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_rs,
    input  logic [31:0]      req1_rt,
    input  logic [3:0]       req1_ctrl,
    output logic [31:0]      alu_rs,
    output logic [31:0]      alu_rt,
    output logic [3:0]       alu_ctrl,
    input  logic [31:0]      alu_rd,
    input  logic             alu_overflow,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp_rd,
    output logic             rsp_overflow,
    output logic             busy,
    output logic [CNT_W-1:0] ovf_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state, state_next;
    logic        prio;
    logic        owner;
    logic        grant_any;
    logic        grant_sel;
    logic        rsp_done;
    logic [31:0] op_rs, op_rt;
    logic [3:0]  op_ctrl;

    assign alu_rs   = op_rs;
    assign alu_rt   = op_rt;
    assign alu_ctrl = op_ctrl;

    // Readies are gated by rst so they stay low while reset is held, even with valids high.
    always_comb begin
        grant_any  = req0_valid | req1_valid;
        grant_sel  = (req0_valid && req1_valid) ? prio : req1_valid;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_done   = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_any && !rst) begin
                    req0_ready = ~grant_sel;
                    req1_ready = grant_sel;
                end
                if (grant_any) state_next = EXEC;
            end
            EXEC: state_next = RESP;
            RESP: begin
                rsp_done = owner ? rsp1_ready : rsp0_ready;
                if (rsp_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rsp0_valid = (state == RESP) && !owner;
    assign rsp1_valid = (state == RESP) && owner;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            prio         <= 1'(PRIO_RESET);
            owner        <= 1'b0;
            op_rs        <= '0;
            op_rt        <= '0;
            op_ctrl      <= '0;
            rsp_rd       <= '0;
            rsp_overflow <= 1'b0;
            ovf_count    <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && grant_any) begin
                owner   <= grant_sel;
                op_rs   <= grant_sel ? req1_rs   : req0_rs;
                op_rt   <= grant_sel ? req1_rt   : req0_rt;
                op_ctrl <= grant_sel ? req1_ctrl : req0_ctrl;
            end
            if (state == EXEC) begin
                rsp_rd       <= alu_rd;
                rsp_overflow <= alu_overflow;
            end
            if (rsp_done) begin
                prio <= ~owner;
                if (rsp_overflow && ovf_count != '1)
                    ovf_count <= ovf_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized and directed checks of alu_arbiter against a transaction model
// A behavioural ALU drives alu_rd; the model tracks pending op, its age and priority.
module tb_alu_arbiter;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 0, req1_valid = 0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_rs = 0, req0_rt = 0, req1_rs = 0, req1_rt = 0;
    logic [3:0]  req0_ctrl = 0, req1_ctrl = 0;
    logic [31:0] alu_rs, alu_rt, alu_rd;
    logic [3:0]  alu_ctrl;
    logic        alu_overflow;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 0, rsp1_ready = 0;
    logic [31:0] rsp_rd;
    logic        rsp_overflow;
    logic        busy;
    logic [CNT_W-1:0] ovf_count;

    alu_arbiter #(.PRIO_RESET(0), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_rs(req0_rs), .req0_rt(req0_rt), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_rs(req1_rs), .req1_rt(req1_rt), .req1_ctrl(req1_ctrl),
        .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_ctrl(alu_ctrl),
        .alu_rd(alu_rd), .alu_overflow(alu_overflow),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_rd(rsp_rd), .rsp_overflow(rsp_overflow),
        .busy(busy), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        logic        v;
        v = 1'b0;
        case (c)
            4'b0000, 4'b0001: begin s = a + b; v = (a[31] == b[31]) && (s[31] != a[31]); end
            4'b1000:          begin s = a - b; v = (a[31] != b[31]) && (s[31] != a[31]); end
            4'b0010:          s = a & b;
            4'b0011:          s = a | b;
            4'b0100:          s = a ^ b;
            default:          s = a ^ ~b;
        endcase
        return {v, s};
    endfunction

    logic [32:0] alu_out;
    assign alu_out      = alu_fn(alu_ctrl, alu_rs, alu_rt);
    assign alu_rd       = alu_out[31:0];
    assign alu_overflow = alu_out[32];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Transaction model: one pending op, its age in cycles since grant, rotating priority.
    bit          m_pend, m_owner, m_prio;
    int          m_age, m_cnt;
    logic [31:0] m_rs, m_rt, m_res;
    logic [3:0]  m_ctrl;
    logic        m_ovf;
    logic [31:0] done_rd[$];
    logic        done_ovf[$];

    task automatic model_reset();
        m_pend = 0; m_owner = 0; m_prio = 0; m_age = 0; m_cnt = 0;
    endtask

    task automatic step(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] c0,
                        input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] c1,
                        input logic r0, input logic r1);
        bit win, e_r0, e_r1, e_v0, e_v1, done;
        logic [32:0] res;
        @(negedge clk);
        req0_valid = v0; req0_rs = a0; req0_rt = b0; req0_ctrl = c0;
        req1_valid = v1; req1_rs = a1; req1_rt = b1; req1_ctrl = c1;
        rsp0_ready = r0; rsp1_ready = r1;
        #1;
        win  = (v0 && v1) ? m_prio : !v0;
        e_r0 = !m_pend && (v0 || v1) && !win;
        e_r1 = !m_pend && (v0 || v1) && win;
        e_v0 = m_pend && m_age >= 1 && !m_owner;
        e_v1 = m_pend && m_age >= 1 && m_owner;
        check("req0_ready", 32'(req0_ready), 32'(e_r0));
        check("req1_ready", 32'(req1_ready), 32'(e_r1));
        check("one_ready", 32'(req0_ready & req1_ready), 32'd0);
        check("busy", 32'(busy), 32'(m_pend));
        check("rsp0_valid", 32'(rsp0_valid), 32'(e_v0));
        check("rsp1_valid", 32'(rsp1_valid), 32'(e_v1));
        check("ovf_count", 32'(ovf_count), 32'(m_cnt));
        if (m_pend) begin
            check("alu_rs", alu_rs, m_rs);
            check("alu_rt", alu_rt, m_rt);
            check("alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
        end
        if (e_v0 || e_v1) begin
            check("rsp_rd", rsp_rd, m_res);
            check("rsp_ovf", 32'(rsp_overflow), 32'(m_ovf));
        end
        done = (e_v0 && r0) || (e_v1 && r1);
        if (done) begin
            done_rd.push_back(rsp_rd);
            done_ovf.push_back(rsp_overflow);
        end
        // Advance the model across the coming rising edge.
        if (!m_pend) begin
            if (v0 || v1) begin
                m_pend = 1; m_age = 0; m_owner = win;
                m_rs = win ? a1 : a0; m_rt = win ? b1 : b0; m_ctrl = win ? c1 : c0;
                res = alu_fn(m_ctrl, m_rs, m_rt);
                m_res = res[31:0]; m_ovf = res[32];
            end
        end else if (done) begin
            m_pend = 0; m_prio = !m_owner;
            if (m_ovf && m_cnt < CNT_MAX) m_cnt++;
        end else if (m_age < 1) begin
            m_age++;
        end
    endtask

    task automatic idle_step(input logic r0, input logic r1);
        step(0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; req0_valid = 1; req1_valid = 1;
        #1;
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_rd", rsp_rd, 32'd0);
        check("rst_rsp_ovf", 32'(rsp_overflow), 32'd0);
        check("rst_alu_rs", alu_rs, 32'd0);
        check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        check("rst_ovf_count", 32'(ovf_count), 32'd0);
        model_reset();
        @(posedge clk);
        #2;
        req0_valid = 0; req1_valid = 0;
        rst = 0;
        done_rd.delete();
        done_ovf.delete();
    endtask

    initial begin
        model_reset();
        do_reset();

        // Single op on req0, granted on the first edge after reset release.
        step(1, 5, 7, 4'b0000, 0, 0, 0, 0, 1, 0);
        idle_step(1, 0);
        idle_step(1, 0);
        idle_step(1, 0);
        check("single_count", done_rd.size(), 1);
        if (done_rd.size() == 1) begin
            check("single_rd", done_rd[0], 32'd12);
            check("single_ovf", 32'(done_ovf[0]), 32'd0);
        end
        check("single_ovf_count", 32'(ovf_count), 32'd0);

        // Contention from reset: req0 first, then req1 gets priority.
        do_reset();
        for (int i = 0; i < 4; i++)
            step(1, 10, 3, 4'b1000, 1, 32'hF0, 32'h3C, 4'b0010, 1, 1);
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        check("contend_count", done_rd.size(), 2);
        if (done_rd.size() == 2) begin
            check("contend_first", done_rd[0], 32'd7);
            check("contend_second", done_rd[1], 32'h30);
        end

        // Signed overflow on req1.
        do_reset();
        step(0, 0, 0, 0, 1, 32'h7FFF_FFFF, 1, 4'b0001, 0, 1);
        idle_step(0, 1);
        idle_step(0, 1);
        idle_step(0, 1);
        check("ovf_count_n", done_rd.size(), 1);
        if (done_rd.size() == 1) begin
            check("ovf_rd", done_rd[0], 32'h8000_0000);
            check("ovf_flag", 32'(done_ovf[0]), 32'd1);
        end
        check("ovf_counter", 32'(ovf_count), 32'd1);

        // Backpressure: owner not ready for 5 RESP cycles, req1 waiting with its ready high.
        do_reset();
        step(1, 100, 1, 4'b1000, 1, 1, 2, 4'b0000, 0, 1);
        for (int i = 0; i < 6; i++)
            step(0, 0, 0, 0, 1, 1, 2, 4'b0000, 0, 1);
        check("bp_held", done_rd.size(), 0);
        step(0, 0, 0, 0, 1, 1, 2, 4'b0000, 1, 1);
        check("bp_done", done_rd.size(), 1);
        if (done_rd.size() == 1) check("bp_rd", done_rd[0], 32'd99);
        for (int i = 0; i < 4; i++) idle_step(1, 1);

        // Reset while the response is pending abandons it.
        do_reset();
        step(1, 1, 1, 4'b0000, 0, 0, 0, 0, 0, 0);
        idle_step(0, 0);
        idle_step(0, 0);
        do_reset();
        for (int i = 0; i < 3; i++) idle_step(1, 1);
        check("abandon_none", done_rd.size(), 0);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a0, b0, a1, b1;
            a0 = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            b0 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
            a1 = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 + 32'($urandom_range(0, 15)) : $urandom;
            b1 = $urandom;
            step($urandom_range(0, 9) < 6, a0, b0, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 9) < 6, a1, b1, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        // Counter saturation with a 2-bit counter: 1, 2, 3, 3.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            logic [31:0] sat_exp[4];
            sat_exp = '{32'd1, 32'd2, 32'd3, 32'd3};
            step(0, 0, 0, 0, 1, 32'h7FFF_FFFF, 32'd5, 4'b0001, 0, 1);
            idle_step(0, 1);
            idle_step(0, 1);
            idle_step(0, 1);
            check($sformatf("sat_%0d", k), 32'(ovf_count), sat_exp[k]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter PRIO_RESET, default 0, index of the requester holding priority after reset (0 or 1).
REQ-002 Parameter CNT_W, default 8, width of the overflow event counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-006 req0_ready / req1_ready  output  1  requester N operation accepted this cycle.
REQ-007 req0_rs, req0_rt / req1_rs, req1_rt  input  32  operands of requester N.
REQ-008 req0_ctrl / req1_ctrl  input  4  ALU operation code of requester N, same encoding as the ALU ctrl port.
REQ-009 alu_rs, alu_rt  output  32  operands driven to the shared ALU.
REQ-010 alu_ctrl  output  4  operation code driven to the shared ALU.
REQ-011 alu_rd  input  32  ALU result.
REQ-012 alu_overflow  input  1  ALU overflow flag.
REQ-013 rsp0_valid / rsp1_valid  output  1  result available for requester N.
REQ-014 rsp0_ready / rsp1_ready  input  1  requester N takes the result.
REQ-015 rsp_rd  output  32  result value, shared by both response channels.
REQ-016 rsp_overflow  output  1  overflow flag of the result.
REQ-017 busy  output  1  high whenever state is not IDLE.
REQ-018 ovf_count  output  CNT_W  saturating count of overflow results delivered.

Function
REQ-019 FSM states IDLE, EXEC, RESP; exactly one operation in flight at any time.
REQ-020 IDLE: if only one req valid, grant it; if both valid, grant the priority holder; if none, stay IDLE.
REQ-021 reqN_ready is combinational: high only in IDLE for the granted requester, otherwise low; at most one ready high per cycle.
REQ-022 On grant (valid and ready), capture rs, rt, ctrl and the owner index into registers; next state EXEC.
REQ-023 alu_rs, alu_rt, alu_ctrl are always driven from the operand registers, never directly from the request ports.
REQ-024 EXEC lasts exactly one cycle: capture alu_rd into rsp_rd and alu_overflow into rsp_overflow; next state RESP.
REQ-025 RESP: rspN_valid high only for the owner; rsp_rd and rsp_overflow held stable until the handshake completes.
REQ-026 RESP with owner rsp_ready high: return to IDLE; priority passes to the other requester; ovf_count increments if rsp_overflow is 1.
REQ-027 RESP with rsp_ready low: remain in RESP indefinitely; the other requester's ready stays low.
REQ-028 Priority changes only on response completion, never on grant.
REQ-029 Minimum latency: grant in cycle T, rspN_valid high in cycle T+2; throughput at most one operation per 3 cycles.
REQ-030 ovf_count saturates at 2^CNT_W-1 and does not wrap.
REQ-031 ctrl codes outside the defined ALU set pass through unchanged; the arbiter neither checks nor rejects them.
REQ-032 The ready of the non-owner requester is ignored; only the owner's handshake completes a response.

Reset
REQ-033 While rst is high: state IDLE, all valid and ready outputs 0, busy 0, operand/ctrl/result registers 0, rsp_overflow 0, ovf_count 0, priority = PRIO_RESET.
REQ-034 Reset asserted mid-operation (EXEC or RESP) abandons the operation; no response is delivered after release.
REQ-035 First grant is possible in the first rising edge after rst deasserts.

Verification
REQ-036 Single op: req0 rs=5, rt=7, ctrl=0000, rsp0_ready=1 -> req0_ready in T, rsp0_valid in T+2, rsp_rd=12, rsp_overflow=0, ovf_count=0.
REQ-037 Contention: both valid from reset (PRIO_RESET=0), req0 ctrl=1000 rs=10 rt=3, req1 ctrl=0010 rs=0xF0 rt=0x3C -> req0 served first (rd=7), then req1 (rd=0x30); no cycle with both readys high.
REQ-038 Overflow: req1 rs=0x7FFFFFFF, rt=1, ctrl=0001 -> rsp_rd=0x80000000, rsp_overflow=1, ovf_count=1 after handshake.
REQ-039 Backpressure: rsp0_ready low 5 cycles in RESP -> rsp0_valid held, rsp_rd stable, req1_ready low throughout, completion on first cycle with ready high.
REQ-040 Reset in RESP with rsp0_valid=1 -> all outputs per REQ-033 immediately, no rsp0_valid after release.
REQ-041 Saturation: CNT_W=2, four overflow results -> ovf_count reads 1, 2, 3, 3.
